mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and HI/LO result bundle between the execute stage and the multiply/divide unit.
// The pipeline side drives as master; the unit is the slave.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_content;
    logic [31:0] rt_content;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, rs_content, rt_content, mthi, mtlo,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, rs_content, rt_content, mthi, mtlo,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider owning the MIPS HI and LO registers.
// Signed ops run on magnitudes; the sign is restored in the FIX cycle.
module mult_div_unit (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        is_div_q, is_div_d;
    logic        neg_q, neg_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] rs_q, rs_d;
    logic [31:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        signed_op;
    logic [31:0] rs_abs, rt_abs;
    logic [32:0] mul_sum;
    logic [32:0] div_shift, div_trial;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign accept    = (state_q == StIdle) && bus.start;
    assign signed_op = ~bus.op[0];
    assign rs_abs    = (signed_op && bus.rs_content[31]) ? -bus.rs_content : bus.rs_content;
    assign rt_abs    = (signed_op && bus.rt_content[31]) ? -bus.rt_content : bus.rt_content;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (cnt_q == 6'd31) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy = (state_q != StIdle);
        bus.done = done_q;
        bus.HI   = hi_q;
        bus.LO   = lo_q;
    end

    // Multiply: accumulator high half gains the multiplicand when the multiplier LSB is set.
    // Divide: acc[63:32] is the partial remainder, acc[31:0] shifts dividend out, quotient in.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_trial = div_shift - {1'b0, b_q};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        cnt_d      = cnt_q;
        done_d     = (state_q == StFix);
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        rs_d       = rs_q;
        b_d        = b_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        if (accept) begin
            cnt_d      = 6'd0;
            is_div_d   = bus.op[1];
            neg_d      = signed_op && (bus.rs_content[31] ^ bus.rt_content[31]);
            neg_rem_d  = signed_op && bus.rs_content[31];
            div_zero_d = bus.op[1] && (bus.rt_content == 32'd0);
            rs_d       = bus.rs_content;
            b_d        = bus.op[1] ? rt_abs : rs_abs;
            acc_d      = {32'd0, bus.op[1] ? rs_abs : rt_abs};
        end else if (state_q == StIdle) begin
            if (bus.mthi) hi_d = bus.rs_content;
            if (bus.mtlo) lo_d = bus.rs_content;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 6'd1;
            if (is_div_q) begin
                if (!div_trial[32]) begin
                    acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[31:1]};
            end
        end else if (state_q == StFix) begin
            if (!is_div_q) begin
                hi_d = prod_fix[63:32];
                lo_d = prod_fix[31:0];
            end else if (div_zero_q) begin
                hi_d = rs_q;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 6'd0;
            done_q     <= 1'b0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rs_q       <= 32'd0;
            b_q        <= 32'd0;
            acc_q      <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            rs_q       <= rs_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and random checks of mult_div_unit against an arithmetic reference of MIPS HI/LO semantics.
module tb_mult_div_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Returns {HI, LO}
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 2'd0) return sa * sb;
        if (op == 2'd1) return ua * ub;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 2'd2) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge while idle; returns 1 time unit after the accept edge.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start      = 1'b1;
        bus.op         = op;
        bus.rs_content = a;
        bus.rt_content = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Edges until done is seen (0 if never), and busy samples counted meanwhile.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string tag);
        int lat, bcnt;
        start_op(op, a, b);
        wait_done(lat, bcnt);
        check($sformatf("%s.latency", tag), 64'(lat), 64'd33);
        check($sformatf("%s.busy_cycles", tag), 64'(bcnt), 64'd33);
        check($sformatf("%s.busy_at_done", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s.hilo", tag), {bus.HI, bus.LO}, exp);
        @(posedge clk);
        #1;
        check($sformatf("%s.done_cleared", tag), 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          lat, bcnt, seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.rs_content = 32'd0;
        bus.rt_content = 32'd0;
        bus.mthi       = 1'b0;
        bus.mtlo       = 1'b0;
        #2;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hilo", {bus.HI, bus.LO}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
        run_op(2'd0, 32'd5, 32'd6, 64'd30, "mult_5x6");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        run_op(2'd3, 32'd7, 32'd2, {32'd1, 32'd3}, "divu_7_2");
        run_op(2'd3, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, "divu_by0");
        run_op(2'd2, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF}, "div_by0");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_ovf");

        // MTLO alone, then MTHI and MTLO together
        bus.rs_content = 32'hA5A5_A5A5;
        bus.mtlo       = 1'b1;
        @(posedge clk);
        #1 bus.mtlo = 1'b0;
        check("mtlo.hilo", {bus.HI, bus.LO}, {32'd0, 32'hA5A5_A5A5});
        bus.rs_content = 32'h0BAD_F00D;
        bus.mthi       = 1'b1;
        bus.mtlo       = 1'b1;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_mtlo.hilo", {bus.HI, bus.LO}, {32'h0BAD_F00D, 32'h0BAD_F00D});

        // start wins over MTLO in the same cycle
        bus.mtlo = 1'b1;
        start_op(2'd1, 32'd3, 32'd4);
        bus.mtlo = 1'b0;
        check("start_wins.hilo_held", {bus.HI, bus.LO}, {32'h0BAD_F00D, 32'h0BAD_F00D});
        wait_done(lat, bcnt);
        check("start_wins.latency", 64'(lat), 64'd33);
        check("start_wins.hilo", {bus.HI, bus.LO}, 64'd12);

        // start and MTHI while busy are ignored
        @(posedge clk);
        #1;
        start_op(2'd3, 32'd100, 32'd7);
        bus.start      = 1'b1;
        bus.op         = 2'd0;
        bus.rs_content = 32'hDEAD_BEEF;
        bus.rt_content = 32'd9;
        bus.mthi       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        check("busy_ignore.hi_held", {bus.HI, bus.LO}, 64'd12);
        wait_done(lat, bcnt);
        check("busy_ignore.latency", 64'(lat), 64'd30);
        check("busy_ignore.hilo", {bus.HI, bus.LO}, {32'd2, 32'd14});
        @(posedge clk);
        #1;
        check("busy_ignore.no_queue", {62'd0, bus.busy, bus.done}, 64'd0);

        // Back-to-back: start in the done cycle
        start_op(2'd0, 32'd5, 32'd6);
        wait_done(lat, bcnt);
        check("b2b_first.hilo", {bus.HI, bus.LO}, 64'd30);
        start_op(2'd3, 32'd7, 32'd2);
        wait_done(lat, bcnt);
        check("b2b_second.latency", 64'(lat), 64'd33);
        check("b2b_second.hilo", {bus.HI, bus.LO}, {32'd1, 32'd3});
        @(posedge clk);
        #1;

        // Reset at RUN iteration 10
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_reset.hilo", {bus.HI, bus.LO}, 64'd0);
        check("mid_reset.busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        check("mid_reset.no_done", 64'(seen), 64'd0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, "after_reset");

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, ref_model(rop, ra, rb), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
